sw_result_collector: RTL and testbench
======================================

// Module: sw_result_collector
// PURPOSE
//  Parametrised on-chip scoreboard for the SmithWaterman core's result stream
//  (valid/result/change_q). Tracks target and query indices, the per-query best
//  target, and the count of targets at or above a programmable threshold.
//  Each finished query's summary record goes into a DEPTH-entry FIFO read with a
//  valid/ready handshake. Sits beside the core so that multi-query runs need no
//  bench-side bookkeeping.
// PARAMETERS
//  CALC_W   16  width of result_i / score fields (matches core CALC_BIT)
//  T_IDX_W  10  width of target index and target counters
//  Q_IDX_W  10  width of query index
//  HIT_W     8  width of the threshold-hit counter (saturating)
//  DEPTH     4  record FIFO entries; power of two, >= 2
// PORTS
//  clk               in   1        clock, rising edge
//  rst_n             in   1        asynchronous active-low reset
//  clr_i             in   1        synchronous clear of all state
//  valid_i           in   1        core result strobe
//  result_i          in   CALC_W   score for current target (unsigned)
//  change_q_i        in   1        qualifies valid_i: last target of this query
//  threshold_i       in   CALC_W   hit threshold; quasi-static during a query
//  rec_ready_i       in   1        consumer accepts the head record
//  rec_valid_o       out  1        FIFO not empty
//  rec_q_idx_o       out  Q_IDX_W  query index of the head record
//  rec_best_t_o      out  T_IDX_W  target index with the highest score
//  rec_best_score_o  out  CALC_W   that score
//  rec_hits_o        out  HIT_W    number of targets with result_i >= threshold_i
//  rec_num_t_o       out  T_IDX_W  targets seen minus 1 (saturating)
//  rec_tsat_o        out  1        target counter saturated during this query
//  fifo_full_o       out  1        FIFO holds DEPTH records
//  drop_o            out  1        sticky: at least one record was lost
//  q_count_o         out  Q_IDX_W  queries completed, including dropped ones (wraps)
// BEHAVIOUR
//  Reset / clear: every register and output goes to 0, the FIFO empties and
//   drop_o clears. clr_i has priority over valid_i and over a FIFO pop in the same cycle.
//  Accumulate: a beat is a cycle with valid_i=1. Per beat:
//   - t_cnt supplies the index of that beat (0 for the first beat of a query).
//   - best updates when result_i > best_score (strict compare). On a tie the
//     earlier target wins. The first beat of a query always loads best.
//   - hits increments if result_i >= threshold_i and saturates at 2^HIT_W-1.
//   - t_cnt increments and saturates at 2^T_IDX_W-1. When it saturates, tsat is
//     set and later beats keep the saturated index.
//  Query end: on a beat with change_q_i=1:
//   - That beat is folded into the record first.
//   - The record {q_idx, best_t, best_score, hits, t_cnt, tsat} is pushed.
//   - Accumulators reset for the next query.
//   - q_idx and q_count_o increment; both wrap modulo 2^Q_IDX_W.
//   change_q_i without valid_i is ignored.
//  FIFO:
//   - A push is written at the rising edge of the change_q beat.
//   - rec_valid_o rises the following cycle (latency 1) if the FIFO was empty.
//   - A pop happens when rec_valid_o & rec_ready_i.
//   - Outputs present the head entry and stay stable while rec_valid_o=1 and
//     rec_ready_i=0.
//   - Full with pop in the same cycle: the push is accepted and occupancy is unchanged.
//   - Full with no pop: the record is dropped, drop_o is set (sticky until clr/reset),
//     and q_idx still advances.
//   - Empty with rec_ready_i=1: no effect.
//   - Pointers wrap modulo DEPTH.
//  Async reset mid-query discards the partial query. The core must restart.
// TESTING
//  T1 reset: rst_n=0 mid-beat -> all outputs 0 immediately. rec_valid_o stays 0
//     after release.
//  T2 single query, threshold=10, scores 5,12,12,3 (last with change_q)
//     -> one record q=0, best_t=1, score=12, hits=2, num_t=3, tsat=0.
//  T3 back-to-back: 3 queries of 2 beats each, rec_ready_i=1 throughout
//     -> records q=0,1,2 each appear 1 cycle after their change_q beat.
//     Final q_count_o=3.
//  T4 overflow, DEPTH=4, rec_ready_i=0, 5 queries
//     -> fifo_full_o after the 4th record. 5th record dropped, drop_o=1,
//     q_count_o=5. Draining yields q=0..3 in order.
//  T5 full+pop same cycle: with the FIFO full, assert rec_ready_i on the change_q
//     beat -> no drop, fifo_full_o stays 1. The head advances to the next q.
//  T6 saturation, T_IDX_W=3: 10 beats in one query
//     -> num_t=7, tsat=1, best_t <= 7. clr_i mid-query then leaves all counters 0.

Source files
------------

// File: rtl/sw_result_collector.sv
// Scoreboard beside the SmithWaterman core: folds the per-target result stream
// into one summary record per query and queues records in a small valid/ready FIFO.
module sw_result_collector #(
  parameter int CALC_W  = 16,
  parameter int T_IDX_W = 10,
  parameter int Q_IDX_W = 10,
  parameter int HIT_W   = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               valid_i,
  input  logic [CALC_W-1:0]  result_i,
  input  logic               change_q_i,
  input  logic [CALC_W-1:0]  threshold_i,
  input  logic               rec_ready_i,
  output logic               rec_valid_o,
  output logic [Q_IDX_W-1:0] rec_q_idx_o,
  output logic [T_IDX_W-1:0] rec_best_t_o,
  output logic [CALC_W-1:0]  rec_best_score_o,
  output logic [HIT_W-1:0]   rec_hits_o,
  output logic [T_IDX_W-1:0] rec_num_t_o,
  output logic               rec_tsat_o,
  output logic               fifo_full_o,
  output logic               drop_o,
  output logic [Q_IDX_W-1:0] q_count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = Q_IDX_W + 2 * T_IDX_W + CALC_W + HIT_W + 1;
  localparam logic [T_IDX_W-1:0] T_MAX    = {T_IDX_W{1'b1}};
  localparam logic [HIT_W-1:0]   H_MAX    = {HIT_W{1'b1}};
  localparam logic [PTR_W:0]     OCC_FULL = (PTR_W + 1)'(DEPTH);

  logic [T_IDX_W-1:0] t_cnt_q, t_cnt_d;
  logic [T_IDX_W-1:0] best_t_q, best_t_d;
  logic [CALC_W-1:0]  best_score_q, best_score_d;
  logic [HIT_W-1:0]   hits_q, hits_d;
  logic               tsat_q, tsat_d;
  logic [Q_IDX_W-1:0] q_idx_q, q_idx_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic               drop_q, drop_d;
  logic [REC_W-1:0]   mem_q [DEPTH];
  logic [REC_W-1:0]   mem_d [DEPTH];

  logic               best_upd_s;
  logic [T_IDX_W-1:0] fold_best_t_s;
  logic [CALC_W-1:0]  fold_best_score_s;
  logic [HIT_W-1:0]   fold_hits_s;
  logic               fold_tsat_s;
  logic [T_IDX_W-1:0] next_t_s;
  logic [PTR_W:0]     occ_s;
  logic               empty_s, full_s, pop_s, push_s, lost_s, q_end_s;
  logic [REC_W-1:0]   rec_s, head_s;

  // A zero count with tsat clear can only mean no beat has arrived yet in this query.
  always_comb begin
    best_upd_s        = ((t_cnt_q == '0) && !tsat_q) || (result_i > best_score_q);
    fold_best_t_s     = best_upd_s ? t_cnt_q : best_t_q;
    fold_best_score_s = best_upd_s ? result_i : best_score_q;
    fold_hits_s       = ((result_i >= threshold_i) && (hits_q != H_MAX)) ?
                        hits_q + HIT_W'(1) : hits_q;
    fold_tsat_s       = tsat_q | (t_cnt_q == T_MAX);
    next_t_s          = (t_cnt_q == T_MAX) ? T_MAX : t_cnt_q + T_IDX_W'(1);
    q_end_s           = valid_i & change_q_i;
    occ_s             = wr_ptr_q - rd_ptr_q;
    empty_s           = (occ_s == '0);
    full_s            = (occ_s == OCC_FULL);
    pop_s             = !empty_s && rec_ready_i;
    push_s            = q_end_s && (!full_s || pop_s);
    lost_s            = q_end_s && full_s && !pop_s;
    rec_s             = {q_idx_q, fold_best_t_s, fold_best_score_s, fold_hits_s,
                         t_cnt_q, fold_tsat_s};
  end

  // Next-state: clear wins over everything, else fold the beat and service the FIFO.
  always_comb begin
    t_cnt_d      = t_cnt_q;
    best_t_d     = best_t_q;
    best_score_d = best_score_q;
    hits_d       = hits_q;
    tsat_d       = tsat_q;
    q_idx_d      = q_idx_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_d       = drop_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (clr_i) begin
      t_cnt_d      = '0;
      best_t_d     = '0;
      best_score_d = '0;
      hits_d       = '0;
      tsat_d       = 1'b0;
      q_idx_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      drop_d       = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
    end else begin
      if (valid_i && change_q_i) begin
        t_cnt_d      = '0;
        best_t_d     = '0;
        best_score_d = '0;
        hits_d       = '0;
        tsat_d       = 1'b0;
        q_idx_d      = q_idx_q + Q_IDX_W'(1);
      end else if (valid_i) begin
        t_cnt_d      = next_t_s;
        best_t_d     = fold_best_t_s;
        best_score_d = fold_best_score_s;
        hits_d       = fold_hits_s;
        tsat_d       = fold_tsat_s;
      end else begin
        t_cnt_d      = t_cnt_q;
      end
      if (push_s) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = rec_s;
        wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (lost_s) begin
        drop_d = 1'b1;
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_cnt_q      <= '0;
      best_t_q     <= '0;
      best_score_q <= '0;
      hits_q       <= '0;
      tsat_q       <= 1'b0;
      q_idx_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      t_cnt_q      <= t_cnt_d;
      best_t_q     <= best_t_d;
      best_score_q <= best_score_d;
      hits_q       <= hits_d;
      tsat_q       <= tsat_d;
      q_idx_q      <= q_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_q       <= drop_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Head fields read as zero whenever the FIFO is empty.
  assign head_s      = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign rec_valid_o = !empty_s;
  assign {rec_q_idx_o, rec_best_t_o, rec_best_score_o, rec_hits_o,
          rec_num_t_o, rec_tsat_o} = rec_valid_o ? head_s : {REC_W{1'b0}};
  assign fifo_full_o = full_s;
  assign drop_o      = drop_q;
  assign q_count_o   = q_idx_q;
endmodule

// File: tb/tb_sw_result_collector.sv
// Randomized self-checking bench for sw_result_collector against a queue-based
// record model (T_IDX_W=3 so target saturation is reachable).
module tb_sw_result_collector;
  localparam int CALC_W = 16, T_IDX_W = 3, Q_IDX_W = 10, HIT_W = 8, DEPTH = 4;
  localparam int TMAX = (1 << T_IDX_W) - 1;
  localparam int HMAX = (1 << HIT_W) - 1;
  localparam int RW = Q_IDX_W + 2 * T_IDX_W + CALC_W + HIT_W + 1;

  logic clk = 1'b0, rst_n = 1'b0, clr_i = 1'b0, valid_i = 1'b0, change_q_i = 1'b0;
  logic rec_ready_i = 1'b0;
  logic [CALC_W-1:0] result_i = '0, threshold_i = '0;
  logic rec_valid_o, rec_tsat_o, fifo_full_o, drop_o;
  logic [Q_IDX_W-1:0] rec_q_idx_o, q_count_o;
  logic [T_IDX_W-1:0] rec_best_t_o, rec_num_t_o;
  logic [CALC_W-1:0] rec_best_score_o;
  logic [HIT_W-1:0] rec_hits_o;
  logic [RW-1:0] dut_head;

  int errors = 0, checks = 0;

  typedef struct { int q; int bt; int bs; int hits; int nt; bit ts; } rec_t;
  rec_t mq[$];
  int cur[$];
  int m_qcount = 0;
  bit m_drop = 1'b0;
  int thr = 0;

  sw_result_collector #(.CALC_W(CALC_W), .T_IDX_W(T_IDX_W), .Q_IDX_W(Q_IDX_W),
                        .HIT_W(HIT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .valid_i(valid_i), .result_i(result_i),
    .change_q_i(change_q_i), .threshold_i(threshold_i), .rec_ready_i(rec_ready_i),
    .rec_valid_o(rec_valid_o), .rec_q_idx_o(rec_q_idx_o), .rec_best_t_o(rec_best_t_o),
    .rec_best_score_o(rec_best_score_o), .rec_hits_o(rec_hits_o),
    .rec_num_t_o(rec_num_t_o), .rec_tsat_o(rec_tsat_o), .fifo_full_o(fifo_full_o),
    .drop_o(drop_o), .q_count_o(q_count_o));

  assign dut_head = {rec_q_idx_o, rec_best_t_o, rec_best_score_o, rec_hits_o,
                     rec_num_t_o, rec_tsat_o};

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] pack(rec_t r);
    return {Q_IDX_W'(r.q), T_IDX_W'(r.bt), CALC_W'(r.bs), HIT_W'(r.hits),
            T_IDX_W'(r.nt), r.ts};
  endfunction

  // Summary of the scores collected for the current query.
  function automatic rec_t make_rec();
    rec_t r;
    int n;
    n = cur.size();
    r.q = m_qcount % (1 << Q_IDX_W);
    r.bt = 0;
    r.bs = cur[0];
    r.hits = 0;
    foreach (cur[i]) begin
      if (cur[i] > r.bs) begin
        r.bs = cur[i];
        r.bt = (i > TMAX) ? TMAX : i;
      end
      if (cur[i] >= thr) r.hits++;
    end
    if (r.hits > HMAX) r.hits = HMAX;
    r.nt = (n - 1 > TMAX) ? TMAX : n - 1;
    r.ts = (n > TMAX);
    return r;
  endfunction

  task automatic model_clear();
    mq.delete();
    cur.delete();
    m_qcount = 0;
    m_drop = 1'b0;
  endtask

  // One clock of stimulus; the model follows the same cycle.
  task automatic cyc(bit v, int s, bit last, bit rdy);
    bit pop, was_full;
    rec_t r;
    valid_i = v;
    result_i = CALC_W'(s);
    change_q_i = last;
    rec_ready_i = rdy;
    threshold_i = CALC_W'(thr);
    was_full = (mq.size() == DEPTH);
    pop = rdy && (mq.size() > 0);
    if (pop) void'(mq.pop_front());
    if (v) begin
      cur.push_back(s);
      if (last) begin
        r = make_rec();
        if (!was_full || pop) mq.push_back(r);
        else m_drop = 1'b1;
        m_qcount++;
        cur.delete();
      end
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    change_q_i = 1'b0;
  endtask

  task automatic do_clr(bit v);
    clr_i = 1'b1;
    valid_i = v;
    change_q_i = v;
    rec_ready_i = 1'b1;
    result_i = 16'd99;
    @(posedge clk);
    #1;
    clr_i = 1'b0;
    valid_i = 1'b0;
    change_q_i = 1'b0;
    rec_ready_i = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    thr = 10;
    cyc(1'b1, 20, 1'b1, 1'b0);
    cyc(1'b1, 7, 1'b0, 1'b0);
    cyc(1'b1, 8, 1'b0, 1'b0);
    valid_i = 1'b1;
    result_i = 16'd33;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rec_valid_o, fifo_full_o, drop_o, q_count_o, dut_head} !== '0) begin
      errors++;
      $display("FAIL reset_async: got valid=%0b full=%0b drop=%0b qcnt=%0d head=%h, want all 0",
               rec_valid_o, fifo_full_o, drop_o, q_count_o, dut_head);
    end
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    repeat (3) cyc(1'b0, 0, 1'b0, 1'b1);
    checks++;
    if ({rec_valid_o, q_count_o} !== '0) begin
      errors++;
      $display("FAIL reset_release: got valid=%0b qcnt=%0d, want 0 0", rec_valid_o, q_count_o);
    end
  endtask

  task automatic test_single_query();
    rec_t e;
    e = '{q: 0, bt: 1, bs: 12, hits: 2, nt: 3, ts: 1'b0};
    thr = 10;
    cyc(1'b1, 5, 1'b0, 1'b0);
    cyc(1'b1, 12, 1'b0, 1'b0);
    cyc(1'b1, 12, 1'b0, 1'b0);
    checks++;
    if (rec_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: got %0b want 0", rec_valid_o);
    end
    cyc(1'b1, 3, 1'b1, 1'b0);
    checks++;
    if ({rec_valid_o, dut_head} !== {1'b1, pack(e)}) begin
      errors++;
      $display("FAIL single_record: got valid=%0b head=%h want 1 %h", rec_valid_o, dut_head, pack(e));
    end
    cyc(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if ({rec_valid_o, dut_head, q_count_o} !== {1'b1, pack(e), 10'd1}) begin
      errors++;
      $display("FAIL single_hold: got valid=%0b head=%h qcnt=%0d want 1 %h 1",
               rec_valid_o, dut_head, q_count_o, pack(e));
    end
    cyc(1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (rec_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: got valid=%0b want 0", rec_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    do_clr(1'b0);
    thr = $urandom_range(10, 40);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, $urandom_range(0, 60), 1'b0, 1'b1);
      checks++;
      if (rec_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b_popped_%0d: got valid=%0b want 0", k, rec_valid_o);
      end
      cyc(1'b1, $urandom_range(0, 60), 1'b1, 1'b1);
      checks++;
      if ({rec_valid_o, rec_q_idx_o, dut_head} !== {1'b1, 10'(k), pack(mq[0])}) begin
        errors++;
        $display("FAIL b2b_record_%0d: got valid=%0b q=%0d head=%h want 1 %0d %h",
                 k, rec_valid_o, rec_q_idx_o, dut_head, k, pack(mq[0]));
      end
    end
    cyc(1'b0, 0, 1'b0, 1'b1);
    checks++;
    if ({rec_valid_o, q_count_o} !== {1'b0, 10'd3}) begin
      errors++;
      $display("FAIL b2b_end: got valid=%0b qcnt=%0d want 0 3", rec_valid_o, q_count_o);
    end
  endtask

  task automatic test_overflow();
    int n;
    do_clr(1'b0);
    thr = $urandom_range(10, 40);
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) cyc(1'b1, $urandom_range(0, 60), j == n - 1, 1'b0);
      if (k == 3) begin
        checks++;
        if ({fifo_full_o, drop_o} !== 2'b10) begin
          errors++;
          $display("FAIL ovf_full4: got full=%0b drop=%0b want 1 0", fifo_full_o, drop_o);
        end
      end
    end
    checks++;
    if ({fifo_full_o, drop_o, q_count_o} !== {2'b11, 10'd5}) begin
      errors++;
      $display("FAIL ovf_drop: got full=%0b drop=%0b qcnt=%0d want 1 1 5",
               fifo_full_o, drop_o, q_count_o);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({rec_valid_o, rec_q_idx_o, dut_head} !== {1'b1, 10'(k), pack(mq[0])}) begin
        errors++;
        $display("FAIL ovf_drain_%0d: got valid=%0b q=%0d head=%h want 1 %0d %h",
                 k, rec_valid_o, rec_q_idx_o, dut_head, k, pack(mq[0]));
      end
      cyc(1'b0, 0, 1'b0, 1'b1);
    end
    checks++;
    if ({rec_valid_o, drop_o} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_empty: got valid=%0b drop=%0b want 0 1", rec_valid_o, drop_o);
    end
  endtask

  task automatic test_full_pop();
    do_clr(1'b0);
    thr = $urandom_range(10, 40);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, $urandom_range(0, 60), 1'b0, 1'b0);
      cyc(1'b1, $urandom_range(0, 60), 1'b1, 1'b0);
    end
    cyc(1'b1, $urandom_range(0, 60), 1'b0, 1'b0);
    cyc(1'b1, $urandom_range(0, 60), 1'b1, 1'b1);
    checks++;
    if ({fifo_full_o, drop_o, rec_q_idx_o, dut_head} !== {2'b10, 10'd1, pack(mq[0])}) begin
      errors++;
      $display("FAIL fullpop: got full=%0b drop=%0b q=%0d head=%h want 1 0 1 %h",
               fifo_full_o, drop_o, rec_q_idx_o, dut_head, pack(mq[0]));
    end
    for (int k = 1; k < 5; k++) begin
      checks++;
      if ({rec_valid_o, rec_q_idx_o, dut_head} !== {1'b1, 10'(k), pack(mq[0])}) begin
        errors++;
        $display("FAIL fullpop_drain_%0d: got valid=%0b q=%0d head=%h want 1 %0d %h",
                 k, rec_valid_o, rec_q_idx_o, dut_head, k, pack(mq[0]));
      end
      cyc(1'b0, 0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_saturation();
    rec_t e;
    do_clr(1'b0);
    thr = $urandom_range(10, 40);
    for (int j = 0; j < 10; j++) cyc(1'b1, $urandom_range(0, 60), j == 9, 1'b0);
    checks++;
    if ({rec_num_t_o, rec_tsat_o} !== {3'd7, 1'b1}) begin
      errors++;
      $display("FAIL sat_count: got num_t=%0d tsat=%0b want 7 1", rec_num_t_o, rec_tsat_o);
    end
    checks++;
    if (dut_head !== pack(mq[0])) begin
      errors++;
      $display("FAIL sat_record: got %h want %h", dut_head, pack(mq[0]));
    end
    cyc(1'b0, 0, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) cyc(1'b1, $urandom_range(0, 60), 1'b0, 1'b0);
    do_clr(1'b1);
    checks++;
    if ({rec_valid_o, drop_o, q_count_o} !== '0) begin
      errors++;
      $display("FAIL clr_state: got valid=%0b drop=%0b qcnt=%0d want 0 0 0",
               rec_valid_o, drop_o, q_count_o);
    end
    thr = 20;
    cyc(1'b1, 25, 1'b1, 1'b0);
    e = '{q: 0, bt: 0, bs: 25, hits: 1, nt: 0, ts: 1'b0};
    checks++;
    if ({rec_valid_o, dut_head} !== {1'b1, pack(e)}) begin
      errors++;
      $display("FAIL clr_fresh_query: got valid=%0b head=%h want 1 %h", rec_valid_o, dut_head, pack(e));
    end
  endtask

  task automatic test_random();
    bit v, last, rdy;
    logic [RW-1:0] eh;
    do_clr(1'b0);
    for (int c = 0; c < 400; c++) begin
      if (cur.size() == 0) thr = $urandom_range(5, 55);
      v = ($urandom_range(0, 3) != 0);
      last = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      cyc(v, $urandom_range(0, 60), last, rdy);
      eh = (mq.size() > 0) ? pack(mq[0]) : '0;
      checks++;
      if ({rec_valid_o, fifo_full_o, drop_o, q_count_o, dut_head} !==
          {mq.size() > 0, mq.size() == DEPTH, m_drop, Q_IDX_W'(m_qcount), eh}) begin
        errors++;
        $display("FAIL random_c%0d: got v=%0b f=%0b d=%0b qc=%0d h=%h want v=%0b f=%0b d=%0b qc=%0d h=%h",
                 c, rec_valid_o, fifo_full_o, drop_o, q_count_o, dut_head,
                 mq.size() > 0, mq.size() == DEPTH, m_drop, Q_IDX_W'(m_qcount), eh);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    test_reset();
    test_single_query();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
